// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle MIPS control. It latches the instruction into IR
// and steps FETCH/DECODE/EXEC/MEM/WB. Memory requests are held until the hit
// arrives. Illegal instructions and memory waits that run too long are trapped
// in ERROR. Every instruction that goes back to FETCH is counted in retired.

typedef enum logic [3:0] {
    ALU_SLL  = 4'h0,
    ALU_SRL  = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_SUB  = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_SLT  = 4'hA,
    ALU_SLTU = 4'hB
} aluop_t;

module mc_control_unit #(
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      imemload,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             zero,
    output logic             iREN,
    output logic             dREN,
    output logic             dWEN,
    output logic             irWEN,
    output logic             pcWEN,
    output logic             regWEN,
    output logic [1:0]       pc_sel,
    output logic [1:0]       regW_sel,
    output logic [1:0]       wMemReg_sel,
    output logic [1:0]       portb_sel,
    output logic             porta_sel,
    output logic             immExt_sel,
    output aluop_t           aluOp,
    output logic             halt,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    state_t      cur_state;
    logic [31:0] ir;
    logic [31:0] wait_cnt;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        legal;
    logic        is_j, is_jal, is_jr, is_beq, is_bne, is_lw, is_sw, is_halt;
    logic [1:0]  dec_pc_sel;
    logic        limit_hit;
    logic        ir_unused;

    assign opcode    = ir[31:26];
    assign funct     = ir[5:0];
    // Register and immediate fields go to the datapath directly and are not used here.
    assign ir_unused = ^ir[25:6];

    assign is_j    = (opcode == OP_J);
    assign is_jal  = (opcode == OP_JAL);
    assign is_jr   = (opcode == OP_RTYPE) && (funct == FN_JR);
    assign is_beq  = (opcode == OP_BEQ);
    assign is_bne  = (opcode == OP_BNE);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_halt = (opcode == OP_HALT);

    // The limit is reached when the next wait count would equal MEM_TIMEOUT.
    // A hit in that same cycle is handled before this check.
    assign limit_hit = (MEM_TIMEOUT != 0) && ((wait_cnt + 32'd1) == 32'(MEM_TIMEOUT));

    assign state = cur_state;

    // During FETCH the IR still holds the previous instruction, so PC+4 is forced.
    assign pc_sel = (cur_state == S_FETCH) ? 2'b00 : dec_pc_sel;

    // Decode datapath selects and ALU op from the registered instruction
    always_comb begin
        dec_pc_sel  = 2'b00;
        regW_sel    = 2'b00;
        wMemReg_sel = 2'b00;
        portb_sel   = 2'b00;
        porta_sel   = 1'b0;
        immExt_sel  = 1'b0;
        aluOp       = ALU_ADD;
        legal       = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL:           begin aluOp = ALU_SLL; portb_sel = 2'b01; end
                    FN_SRL:           begin aluOp = ALU_SRL; portb_sel = 2'b01; end
                    FN_JR:            dec_pc_sel = 2'b01;
                    FN_ADD, FN_ADDU:  aluOp = ALU_ADD;
                    FN_SUB, FN_SUBU:  aluOp = ALU_SUB;
                    FN_AND:           aluOp = ALU_AND;
                    FN_OR:            aluOp = ALU_OR;
                    FN_XOR:           aluOp = ALU_XOR;
                    FN_NOR:           aluOp = ALU_NOR;
                    FN_SLT:           aluOp = ALU_SLT;
                    FN_SLTU:          aluOp = ALU_SLTU;
                    default:          legal = 1'b0;
                endcase
            end
            OP_J:    dec_pc_sel = 2'b10;
            OP_JAL: begin
                dec_pc_sel  = 2'b10;
                regW_sel    = 2'b10;
                wMemReg_sel = 2'b10;
            end
            OP_BEQ, OP_BNE: begin
                dec_pc_sel = 2'b11;
                aluOp      = ALU_SUB;
                immExt_sel = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                regW_sel   = 2'b01;
                portb_sel  = 2'b10;
                immExt_sel = 1'b1;
                aluOp      = (opcode == OP_SLTI)  ? ALU_SLT  :
                             (opcode == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                regW_sel  = 2'b01;
                portb_sel = 2'b10;
                aluOp     = (opcode == OP_ANDI) ? ALU_AND :
                            (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
            end
            OP_LUI: begin
                // LUI puts the immediate on port A and shifts it left by the constant 16.
                regW_sel  = 2'b01;
                porta_sel = 1'b1;
                portb_sel = 2'b11;
                aluOp     = ALU_SLL;
            end
            OP_LW: begin
                regW_sel    = 2'b01;
                wMemReg_sel = 2'b01;
                portb_sel   = 2'b10;
                immExt_sel  = 1'b1;
            end
            OP_SW: begin
                portb_sel  = 2'b10;
                immExt_sel = 1'b1;
            end
            OP_HALT: ;
            default: legal = 1'b0;
        endcase
    end

    // Per-state enables; they follow the hits in the same cycle and are held low during reset
    always_comb begin
        iREN   = 1'b0;
        dREN   = 1'b0;
        dWEN   = 1'b0;
        irWEN  = 1'b0;
        pcWEN  = 1'b0;
        regWEN = 1'b0;
        if (!RST) begin
            case (cur_state)
                S_FETCH: begin
                    iREN = 1'b1;
                    if (ihit) begin
                        irWEN = 1'b1;
                        pcWEN = 1'b1;
                    end
                end
                S_DECODE: begin
                    if (is_j || is_jal) pcWEN = 1'b1;
                    if (is_jal)         regWEN = 1'b1;
                end
                S_EXEC: begin
                    if ((is_beq && zero) || (is_bne && !zero) || is_jr) pcWEN = 1'b1;
                end
                S_MEM: begin
                    dREN = is_lw;
                    dWEN = is_sw;
                end
                S_WB:    regWEN = 1'b1;
                default: ;
            endcase
        end
    end

    // State sequencing, IR load, wait counter, sticky flags and retired count
    always_ff @(posedge CLK) begin
        if (RST) begin
            cur_state <= S_FETCH;
            ir        <= '0;
            wait_cnt  <= '0;
            retired   <= '0;
            halt      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (cur_state)
                S_FETCH: begin
                    if (ihit) begin
                        ir        <= imemload;
                        cur_state <= S_DECODE;
                    end else if (limit_hit) begin
                        cur_state <= S_ERROR;
                        err       <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_DECODE: begin
                    if (is_halt) begin
                        cur_state <= S_HALTED;
                        halt      <= 1'b1;
                    end else if (!legal) begin
                        cur_state <= S_ERROR;
                        err       <= 1'b1;
                    end else if (is_j || is_jal) begin
                        cur_state <= S_FETCH;
                        wait_cnt  <= '0;
                        retired   <= retired + CNT_W'(1);
                    end else begin
                        cur_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_lw || is_sw) begin
                        cur_state <= S_MEM;
                        wait_cnt  <= '0;
                    end else if (is_beq || is_bne || is_jr) begin
                        cur_state <= S_FETCH;
                        wait_cnt  <= '0;
                        retired   <= retired + CNT_W'(1);
                    end else begin
                        cur_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dhit) begin
                        if (is_lw) begin
                            cur_state <= S_WB;
                        end else begin
                            cur_state <= S_FETCH;
                            wait_cnt  <= '0;
                            retired   <= retired + CNT_W'(1);
                        end
                    end else if (limit_hit) begin
                        cur_state <= S_ERROR;
                        err       <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_WB: begin
                    cur_state <= S_FETCH;
                    wait_cnt  <= '0;
                    retired   <= retired + CNT_W'(1);
                end
                S_HALTED, S_ERROR: ;
                default: begin
                    cur_state <= S_ERROR;
                    err       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: table of instructions with expected cycle counts, state
// traces, selects and enables, plus hand sequences for reset behaviour.
module tb_mc_control_unit;

    localparam int CW = 4;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          ilat;
        int          dlat;
        logic        rst;
        logic        dec;
        int          cycles;
        logic [2:0]  end_st;
        logic [23:0] trc;
        logic        rwen;
        logic        pcw;
        int          memc;
        logic [1:0]  pcs;
        logic [1:0]  regw;
        logic [1:0]  wmr;
        logic [1:0]  pb;
        logic        pa;
        logic        ie;
        logic [3:0]  op;
    } vec_t;

    logic          CLK;
    logic          RST;
    logic [31:0]   imemload;
    logic          ihit, dhit, zero;
    logic          iREN, dREN, dWEN, irWEN, pcWEN, regWEN;
    logic [1:0]    pc_sel, regW_sel, wMemReg_sel, portb_sel;
    logic          porta_sel, immExt_sel;
    logic [3:0]    alu_op;
    logic          halt, err;
    logic [2:0]    st;
    logic [CW-1:0] retired;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW-1:0] exp_ret  = '0;
    vec_t          exp_q[$];
    vec_t          tbl[21];

    mc_control_unit #(.MEM_TIMEOUT(4), .CNT_W(CW)) u_dut (
        .CLK(CLK), .RST(RST), .imemload(imemload), .ihit(ihit), .dhit(dhit), .zero(zero),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .irWEN(irWEN), .pcWEN(pcWEN), .regWEN(regWEN),
        .pc_sel(pc_sel), .regW_sel(regW_sel), .wMemReg_sel(wMemReg_sel), .portb_sel(portb_sel),
        .porta_sel(porta_sel), .immExt_sel(immExt_sel), .aluOp(alu_op),
        .halt(halt), .err(err), .state(st), .retired(retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; ihit = 1'b0; dhit = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_ret = '0;
    endtask

    // Run one instruction from FETCH until it returns to FETCH or stops.
    task automatic run_instr(input int idx, input vec_t v);
        vec_t        e;
        int          cyc, fw, mw, memc;
        logic        left, seen_rw, seen_pcw;
        logic [1:0]  d_pcs, d_regw, d_wmr, d_pb, w_regw, w_wmr, e_pcs;
        logic        d_pa, d_ie;
        logic [3:0]  d_op;
        logic [23:0] trc;
        string       tag;
        tag = $sformatf("v%0d ", idx);
        if (v.rst) do_reset();
        exp_q.push_back(v);
        cyc = 0; fw = 0; mw = 0; memc = 0;
        left = 1'b0; seen_rw = 1'b0; seen_pcw = 1'b0;
        d_pcs = '0; d_regw = '0; d_wmr = '0; d_pb = '0; d_pa = 1'b0; d_ie = 1'b0; d_op = '0;
        w_regw = '0; w_wmr = '0; e_pcs = '0; trc = '0;
        imemload = v.instr;
        zero     = v.zero;
        while (cyc < 40) begin
            @(negedge CLK);
            ihit = (st == 3'd0) && (fw >= v.ilat);
            dhit = (st == 3'd3) && (mw >= v.dlat);
            #1;
            trc = {trc[20:0], st};
            if (st == 3'd0 && ihit) begin
                check({tag, "fetch irWEN"}, irWEN, 1'b1);
                check({tag, "fetch pcWEN"}, pcWEN, 1'b1);
                check({tag, "fetch pc_sel"}, pc_sel, 2'b00);
                left = 1'b1;
            end
            if (st == 3'd0) fw++;
            if (st == 3'd3) mw++;
            if (st == 3'd1) begin
                d_pcs = pc_sel; d_regw = regW_sel; d_wmr = wMemReg_sel; d_pb = portb_sel;
                d_pa = porta_sel; d_ie = immExt_sel; d_op = alu_op;
            end
            if (dREN || dWEN) memc++;
            if (regWEN) begin seen_rw = 1'b1; w_regw = regW_sel; w_wmr = wMemReg_sel; end
            if (pcWEN && st != 3'd0) begin seen_pcw = 1'b1; e_pcs = pc_sel; end
            cyc++;
            @(posedge CLK); #1;
            if (left && st == 3'd0) break;
            if (st == 3'd5 || st == 3'd6) break;
        end
        ihit = 1'b0; dhit = 1'b0;
        e = exp_q.pop_front();
        if (e.end_st == 3'd0) exp_ret = exp_ret + 1'b1;
        check({tag, "cycles"}, cyc, e.cycles);
        check({tag, "end state"}, st, e.end_st);
        check({tag, "state trace"}, trc, e.trc);
        check({tag, "regWEN seen"}, seen_rw, e.rwen);
        check({tag, "pcWEN seen"}, seen_pcw, e.pcw);
        check({tag, "mem req cycles"}, memc, e.memc);
        check({tag, "retired"}, retired, exp_ret);
        check({tag, "halt"}, halt, (e.end_st == 3'd5));
        check({tag, "err"}, err, (e.end_st == 3'd6));
        if (seen_rw) begin
            check({tag, "wb regW_sel"}, w_regw, e.regw);
            check({tag, "wb wMemReg_sel"}, w_wmr, e.wmr);
        end
        if (seen_pcw) check({tag, "pcWEN pc_sel"}, e_pcs, e.pcs);
        if (e.dec) begin
            check({tag, "pc_sel"}, d_pcs, e.pcs);
            check({tag, "regW_sel"}, d_regw, e.regw);
            check({tag, "wMemReg_sel"}, d_wmr, e.wmr);
            check({tag, "portb_sel"}, d_pb, e.pb);
            check({tag, "porta_sel"}, d_pa, e.pa);
            check({tag, "immExt_sel"}, d_ie, e.ie);
            check({tag, "aluOp"}, d_op, e.op);
        end
        if (e.end_st == 3'd5 || e.end_st == 3'd6) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge CLK);
                ihit = 1'b1; dhit = 1'b1;
                #1;
                check({tag, "sticky state"}, st, e.end_st);
                check({tag, "sticky iREN"}, iREN, 1'b0);
                check({tag, "sticky regWEN"}, regWEN, 1'b0);
                check({tag, "sticky halt"}, halt, (e.end_st == 3'd5));
                check({tag, "sticky err"}, err, (e.end_st == 3'd6));
                check({tag, "sticky retired"}, retired, exp_ret);
                @(posedge CLK); #1;
            end
            ihit = 1'b0; dhit = 1'b0;
        end
    endtask

    initial begin
        //            instr         z     il  dl  rst   dec   cyc st    trace         rw    pw    mc pcs    regw   wmr    pb     pa    ie    op
        tbl[0]  = '{32'h00221821, 1'b0, 0,  0,  1'b1, 1'b1, 4, 3'd0, 24'o0124,     1'b1, 1'b0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'h2};
        tbl[1]  = '{32'h8C220004, 1'b0, 0,  3,  1'b0, 1'b1, 8, 3'd0, 24'o01233334, 1'b1, 1'b0, 4, 2'b00, 2'b01, 2'b01, 2'b10, 1'b0, 1'b1, 4'h2};
        tbl[2]  = '{32'h10220003, 1'b1, 0,  0,  1'b0, 1'b1, 3, 3'd0, 24'o012,      1'b0, 1'b1, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 4'h3};
        tbl[3]  = '{32'h10220003, 1'b0, 0,  0,  1'b0, 1'b1, 3, 3'd0, 24'o012,      1'b0, 1'b0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 4'h3};
        tbl[4]  = '{32'h0C000010, 1'b0, 0,  0,  1'b0, 1'b1, 2, 3'd0, 24'o01,       1'b1, 1'b1, 0, 2'b10, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 4'h2};
        tbl[5]  = '{32'hAC220008, 1'b0, 0,  0,  1'b0, 1'b1, 4, 3'd0, 24'o0123,     1'b0, 1'b0, 1, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 4'h2};
        tbl[6]  = '{32'h00221821, 1'b0, 3,  0,  1'b0, 1'b1, 7, 3'd0, 24'o0000124,  1'b1, 1'b0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'h2};
        tbl[7]  = '{32'h03E00008, 1'b0, 0,  0,  1'b0, 1'b1, 3, 3'd0, 24'o012,      1'b0, 1'b1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'h2};
        tbl[8]  = '{32'h34220FFF, 1'b0, 0,  0,  1'b0, 1'b1, 4, 3'd0, 24'o0124,     1'b1, 1'b0, 0, 2'b00, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0, 4'h5};
        tbl[9]  = '{32'h3C011234, 1'b0, 0,  0,  1'b0, 1'b1, 4, 3'd0, 24'o0124,     1'b1, 1'b0, 0, 2'b00, 2'b01, 2'b00, 2'b11, 1'b1, 1'b0, 4'h0};
        tbl[10] = '{32'h00021080, 1'b0, 0,  0,  1'b0, 1'b1, 4, 3'd0, 24'o0124,     1'b1, 1'b0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 4'h0};
        tbl[11] = '{32'h14220002, 1'b0, 0,  0,  1'b0, 1'b1, 3, 3'd0, 24'o012,      1'b0, 1'b1, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 4'h3};
        tbl[12] = '{32'h14220002, 1'b1, 0,  0,  1'b0, 1'b1, 3, 3'd0, 24'o012,      1'b0, 1'b0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 4'h3};
        tbl[13] = '{32'h08000040, 1'b0, 0,  0,  1'b0, 1'b1, 2, 3'd0, 24'o01,       1'b0, 1'b1, 0, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'h2};
        tbl[14] = '{32'h0022182A, 1'b0, 0,  0,  1'b0, 1'b1, 4, 3'd0, 24'o0124,     1'b1, 1'b0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'hA};
        tbl[15] = '{32'h24420001, 1'b0, 0,  0,  1'b0, 1'b1, 4, 3'd0, 24'o0124,     1'b1, 1'b0, 0, 2'b00, 2'b01, 2'b00, 2'b10, 1'b0, 1'b1, 4'h2};
        tbl[16] = '{32'hAC220008, 1'b0, 0,  2,  1'b0, 1'b1, 6, 3'd0, 24'o012333,   1'b0, 1'b0, 3, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 4'h2};
        tbl[17] = '{32'hFC000000, 1'b0, 0,  0,  1'b0, 1'b1, 2, 3'd5, 24'o01,       1'b0, 1'b0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'h2};
        tbl[18] = '{32'h0000003A, 1'b0, 0,  0,  1'b1, 1'b1, 2, 3'd6, 24'o01,       1'b0, 1'b0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'h2};
        tbl[19] = '{32'h00221821, 1'b0, 99, 0,  1'b1, 1'b0, 4, 3'd6, 24'o0000,     1'b0, 1'b0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'h2};
        tbl[20] = '{32'h0C000010, 1'b0, 0,  0,  1'b1, 1'b1, 2, 3'd0, 24'o01,       1'b1, 1'b1, 0, 2'b10, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 4'h2};

        // Reset state, with hits driven high to show the enables are held low
        RST = 1'b1; ihit = 1'b1; dhit = 1'b1; zero = 1'b0; imemload = 32'h00221821;
        @(negedge CLK);
        check("reset state", st, 3'd0);
        check("reset iREN", iREN, 1'b0);
        check("reset irWEN", irWEN, 1'b0);
        check("reset pcWEN", pcWEN, 1'b0);
        check("reset retired", retired, '0);
        check("reset halt", halt, 1'b0);
        check("reset err", err, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b0; ihit = 1'b0; dhit = 1'b0;
        @(negedge CLK);
        check("release iREN", iREN, 1'b1);
        check("release state", st, 3'd0);
        check("release retired", retired, '0);
        @(posedge CLK); #1;

        for (int i = 0; i < 21; i++) run_instr(i, tbl[i]);

        // Reset while a store waits in MEM: the store is abandoned with no writes
        do_reset();
        imemload = 32'hAC220008; zero = 1'b0;
        @(negedge CLK); ihit = 1'b1;
        @(posedge CLK); #1; ihit = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("midmem state", st, 3'd3);
        check("midmem dWEN held", dWEN, 1'b1);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        check("midmem rst dWEN", dWEN, 1'b0);
        check("midmem rst regWEN", regWEN, 1'b0);
        check("midmem rst pcWEN", pcWEN, 1'b0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("midmem rst state", st, 3'd0);
        check("midmem rst retired", retired, '0);
        check("midmem rst err", err, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("midmem release iREN", iREN, 1'b1);
        check("midmem release dWEN", dWEN, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
